// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw synchronized levels in, debounced level and press pulse out.
interface button_debouncer_if #(
   parameter int unsigned WIDTH = 1
);
   logic [WIDTH-1:0] glitchy_signal;
   logic [WIDTH-1:0] debounced_signal;
   logic [WIDTH-1:0] rise_pulse;

   modport master (
      output glitchy_signal,
      input  debounced_signal,
      input  rise_pulse
   );

   modport slave (
      input  glitchy_signal,
      output debounced_signal,
      output rise_pulse
   );
endinterface

// File: rtl/button_debouncer.sv
// Per-bit button debouncer: a bit reads pressed after PULSE_CNT_MAX consecutive high sample
// ticks, and each new press emits a one-cycle rise pulse. Inputs must already be synchronized.
module button_debouncer #(
   parameter int unsigned WIDTH          = 1,
   parameter int unsigned SAMPLE_CNT_MAX = 25000,
   parameter int unsigned PULSE_CNT_MAX  = 200
) (
   input  logic               clk,
   input  logic               rst,
   button_debouncer_if.slave  bus
);

   localparam int unsigned SAMPLE_W = $clog2(SAMPLE_CNT_MAX);
   localparam int unsigned SAT_W    = $clog2(PULSE_CNT_MAX + 1);
   localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
   localparam logic [SAT_W-1:0]    SAT_FULL    = SAT_W'(PULSE_CNT_MAX);

   logic [SAMPLE_W-1:0] r_sample_cnt;
   logic                w_sample_tick;
   logic [WIDTH-1:0]    w_debounced;
   logic [WIDTH-1:0]    r_prev;

   // Free-running sample prescaler shared by all bits.
   assign w_sample_tick = (r_sample_cnt == SAMPLE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sample_cnt <= '0;
      end else if (w_sample_tick) begin
         r_sample_cnt <= '0;
      end else begin
         r_sample_cnt <= r_sample_cnt + SAMPLE_W'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [SAT_W-1:0] r_sat;

         // Any low cycle clears the run, even on a tick cycle.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_sat <= '0;
            end else if (!bus.glitchy_signal[gi]) begin
               r_sat <= '0;
            end else if (w_sample_tick && (r_sat < SAT_FULL)) begin
               r_sat <= r_sat + SAT_W'(1);
            end
         end

         assign w_debounced[gi] = (r_sat == SAT_FULL);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= '0;
      end else begin
         r_prev <= w_debounced;
      end
   end

   assign bus.debounced_signal = w_debounced;
   assign bus.rise_pulse       = w_debounced & ~r_prev;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed vector table, multi-cycle corner sequences,
// and random stimulus compared every cycle against a tick-counting history model.
module tb_button_debouncer;

   localparam int unsigned W = 4;
   localparam int unsigned S = 4;
   localparam int unsigned P = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   button_debouncer_if #(.WIDTH(W)) bus ();

   button_debouncer #(
      .WIDTH          (W),
      .SAMPLE_CNT_MAX (S),
      .PULSE_CNT_MAX  (P)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Per-cycle history used by the reference model.
   logic         h_rst[$];
   logic [W-1:0] h_in[$];
   int           h_lastrst[$];
   logic [W-1:0] h_deb[$];

   logic [W-1:0] s_deb, s_rise;

   typedef struct {
      logic [W-1:0] g;
      int           len;
      logic [W-1:0] deb;
      logic [W-1:0] rise;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t (cycle %0d): got %b, expected %b", name, $time, cyc, act, exp);
      end
   endtask

   // A bit is debounced in cycle k when the ticks seen since its last low/reset cycle reach P.
   function automatic logic [W-1:0] model_deb(input int k);
      logic [W-1:0] d;
      d = '0;
      for (int i = 0; i < W; i++) begin
         int cnt;
         cnt = 0;
         for (int c = k - 1; c >= 0; c--) begin
            if (h_rst[c] || !h_in[c][i]) break;
            if (((c - h_lastrst[c] - 1) % S) == S - 1) cnt++;
            if (cnt >= P) break;
         end
         d[i] = (cnt >= P);
      end
      return d;
   endfunction

   task automatic step(input logic r, input logic [W-1:0] g);
      int k;
      logic [W-1:0] ed, er;
      rst = r;
      bus.glitchy_signal = g;
      @(negedge clk);
      h_rst.push_back(r);
      h_in.push_back(g);
      k = h_rst.size() - 1;
      h_lastrst.push_back((r || k == 0) ? k : h_lastrst[k-1]);
      ed = model_deb(k);
      er = (k > 0) ? (ed & ~h_deb[k-1]) : '0;
      h_deb.push_back(ed);
      s_deb  = bus.debounced_signal;
      s_rise = bus.rise_pulse;
      check("model_debounced", s_deb, ed);
      check("model_rise", s_rise, er);
      @(posedge clk);
      #1;
      if (r) cyc = 0;
      else cyc++;
   endtask

   initial begin
      logic [W-1:0] g;

      tbl[0] = '{g: 4'b0001, len: 12, deb: 4'b0000, rise: 4'b0000};
      tbl[1] = '{g: 4'b0001, len: 1,  deb: 4'b0001, rise: 4'b0001};
      tbl[2] = '{g: 4'b0001, len: 7,  deb: 4'b0001, rise: 4'b0000};
      tbl[3] = '{g: 4'b0000, len: 1,  deb: 4'b0001, rise: 4'b0000};
      tbl[4] = '{g: 4'b0000, len: 1,  deb: 4'b0000, rise: 4'b0000};
      tbl[5] = '{g: 4'b0001, len: 10, deb: 4'b0000, rise: 4'b0000};
      tbl[6] = '{g: 4'b0001, len: 1,  deb: 4'b0001, rise: 4'b0001};
      tbl[7] = '{g: 4'b0001, len: 1,  deb: 4'b0001, rise: 4'b0000};

      rst = 1'b1;
      bus.glitchy_signal = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state.
      step(1'b1, '0);
      check("reset_debounced", s_deb, '0);
      check("reset_rise", s_rise, '0);

      // Steady press, release and re-press on bit 0.
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < tbl[i].len; j++) step(1'b0, tbl[i].g);
         check($sformatf("tbl%0d_debounced", i), s_deb, tbl[i].deb);
         check($sformatf("tbl%0d_rise", i), s_rise, tbl[i].rise);
      end

      // Single-cycle glitch on bit 1 at cycle 9.
      step(1'b1, '0);
      for (int c = 0; c < 22; c++) begin
         step(1'b0, (c == 9) ? 4'b0000 : 4'b0010);
         if (c == 19) check("glitch_c19_debounced", s_deb, 4'b0000);
         if (c == 20) begin
            check("glitch_c20_debounced", s_deb, 4'b0010);
            check("glitch_c20_rise", s_rise, 4'b0010);
         end
         if (c == 21) check("glitch_c21_rise", s_rise, 4'b0000);
      end

      // Bounce on bit 2, toggling every two cycles.
      step(1'b1, '0);
      for (int c = 0; c < 40; c++) begin
         step(1'b0, (((c / 2) % 2) == 1) ? 4'b0100 : 4'b0000);
         check("bounce_debounced", s_deb, 4'b0000);
         check("bounce_rise", s_rise, 4'b0000);
      end

      // Reset while all bits are debounced.
      step(1'b1, '0);
      for (int c = 0; c < 15; c++) begin
         step(1'b0, 4'b1111);
         if (c == 12) check("all_c12_rise", s_rise, 4'b1111);
         if (c == 14) check("all_c14_debounced", s_deb, 4'b1111);
      end
      step(1'b1, 4'b1111);
      for (int c = 0; c < 14; c++) begin
         step(1'b0, 4'b1111);
         if (c == 0) begin
            check("rst_mid_c0_debounced", s_deb, 4'b0000);
            check("rst_mid_c0_rise", s_rise, 4'b0000);
         end
         if (c == 11) check("rst_mid_c11_debounced", s_deb, 4'b0000);
         if (c == 12) begin
            check("rst_mid_c12_debounced", s_deb, 4'b1111);
            check("rst_mid_c12_rise", s_rise, 4'b1111);
         end
         if (c == 13) check("rst_mid_c13_rise", s_rise, 4'b0000);
      end

      // Bit 3 low exactly on the tick where it would have reached full count.
      step(1'b1, '0);
      for (int c = 0; c < 26; c++) begin
         step(1'b0, (c == 11) ? 4'b0000 : 4'b1000);
         if (c == 12) check("clr_tick_c12_debounced", s_deb, 4'b0000);
         if (c == 23) check("clr_tick_c23_debounced", s_deb, 4'b0000);
         if (c == 24) begin
            check("clr_tick_c24_debounced", s_deb, 4'b1000);
            check("clr_tick_c24_rise", s_rise, 4'b1000);
         end
      end

      // Random bursts with occasional resets, checked by the model every cycle.
      step(1'b1, '0);
      g = W'($urandom);
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 15) == 0) g[i] = ~g[i];
         end
         step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, g);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
